// File: rtl/rx_pkt_ctrl.sv
// rx_pkt_ctrl: USB receive packet controller; validates SYNC, strobes FIFO writes per data byte,
// tracks byte count and a sticky receive error per packet.
module rx_pkt_ctrl #(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_en,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       eop_error,
  input  logic       byte_done,
  input  logic [7:0] rx_byte,
  input  logic       buffer_full,
  output logic       det_en,
  output logic       det_clear,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic [6:0] byte_count
);
  typedef enum logic [2:0] {IDLE, SYNC, CHK_SYNC, RECEIVE, STORE, DONE, ERR_WAIT} state_t;
  localparam logic [6:0] MAXC = 7'(MAX_BYTES);
  state_t state_q, state_d;
  logic [7:0] sync_q, sync_d;
  logic [6:0] count_q, count_d;
  logic r_error_q, r_error_d, rcving_q;
  logic q_eop, q_err;
  assign q_eop = bit_en & eop;
  assign q_err = bit_en & eop_error;
  always_comb begin
    state_d = state_q;
    sync_d = sync_q;
    count_d = count_q;
    r_error_d = r_error_q;
    det_clear = 1'b0;
    w_enable = 1'b0;
    case (state_q)
      IDLE: if (d_edge) begin
        state_d = SYNC;
        det_clear = 1'b1;
        r_error_d = 1'b0;
        count_d = '0;
      end
      SYNC: if (q_eop | q_err) begin
        state_d = IDLE;
        r_error_d = 1'b1;
      end else if (byte_done) begin
        state_d = CHK_SYNC;
        sync_d = rx_byte;
      end
      CHK_SYNC: state_d = (sync_q == 8'h80) ? RECEIVE : ERR_WAIT;
      RECEIVE: state_d = q_err ? ERR_WAIT : q_eop ? DONE : byte_done ? STORE : RECEIVE;
      STORE: if (buffer_full || count_q == MAXC) state_d = ERR_WAIT;
      else begin
        w_enable = 1'b1;
        count_d = count_q + 7'd1;
        state_d = RECEIVE;
      end
      DONE: begin
        det_clear = 1'b1;
        state_d = IDLE;
        if (count_q == '0) r_error_d = 1'b1;
      end
      ERR_WAIT: if (q_eop | q_err) begin
        state_d = IDLE;
        det_clear = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // error stays visible for the whole wait for end of packet
    if (state_d == ERR_WAIT) r_error_d = 1'b1;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sync_q <= '0;
      count_q <= '0;
      r_error_q <= 1'b0;
      rcving_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      count_q <= count_d;
      r_error_q <= r_error_d;
      rcving_q <= (state_d != IDLE);
    end
  end
  assign det_en = bit_en & (state_q != IDLE);
  assign rcving = rcving_q;
  assign r_error = r_error_q;
  assign byte_count = count_q;
endmodule

// File: doc/rx_pkt_ctrl.md
RX_PKT_CTRL -- requirements
Module: rx_pkt_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_BYTES, default 64, meaning the maximum data bytes accepted per packet after SYNC.
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port n_rst, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port bit_en, input, 1, one-cycle strobe per USB bit period.
REQ-005 The block SHALL have port d_edge, input, 1, one-cycle pulse on any D+/D- transition.
REQ-006 The block SHALL have port eop, input, 1, clean end-of-packet flag from the EOP detector.
REQ-007 The block SHALL have port eop_error, input, 1, malformed-SE0 flag from the EOP detector.
REQ-008 The block SHALL have port byte_done, input, 1, one-cycle pulse when 8 bits are shifted in.
REQ-009 The block SHALL have port rx_byte, input, 8, most recently completed byte, valid while byte_done=1.
REQ-010 The block SHALL have port buffer_full, input, 1, RX FIFO cannot accept a write.
REQ-011 The block SHALL have port det_en, output, 1, enable for the EOP detector.
REQ-012 The block SHALL have port det_clear, output, 1, synchronous clear for the EOP detector counter.
REQ-013 The block SHALL have port rcving, output, 1, packet reception in progress.
REQ-014 The block SHALL have port w_enable, output, 1, one-cycle RX FIFO write strobe for rx_byte held from STORE entry.
REQ-015 The block SHALL have port r_error, output, 1, sticky receive error for the current/last packet.
REQ-016 The block SHALL have port byte_count, output, 7, data bytes written in the current packet.

Function
REQ-017 The FSM SHALL have states IDLE, SYNC, CHK_SYNC, RECEIVE, STORE, DONE, ERR_WAIT.
REQ-018 eop and eop_error SHALL be acted on only in cycles where bit_en=1 ("qualified").
REQ-019 IDLE: on d_edge -> SYNC; det_clear=1 that cycle; r_error cleared and byte_count zeroed at that edge.
REQ-020 SYNC: qualified eop or eop_error -> ERR_WAIT-bypass to IDLE with r_error set; else byte_done -> CHK_SYNC with rx_byte latched.
REQ-021 CHK_SYNC (one cycle): latched byte == 8'h80 -> RECEIVE; otherwise -> ERR_WAIT.
REQ-022 RECEIVE priority, highest first: qualified eop_error -> ERR_WAIT; qualified eop -> DONE; byte_done -> STORE with rx_byte latched.
REQ-023 STORE (one cycle): buffer_full=1 or byte_count==MAX_BYTES -> ERR_WAIT with no write; else w_enable=1, byte_count+1, -> RECEIVE.
REQ-024 DONE (one cycle): byte_count==0 sets r_error; det_clear=1; -> IDLE.
REQ-025 ERR_WAIT: r_error=1; qualified eop or eop_error -> IDLE with det_clear=1; d_edge ignored.
REQ-026 r_error SHALL remain set in IDLE until the next IDLE->SYNC transition.
REQ-027 rcving SHALL be 1 in every state except IDLE, registered (no combinational path from inputs).
REQ-028 det_en SHALL equal bit_en in every state except IDLE, and 0 in IDLE.
REQ-029 w_enable SHALL assert at most once per STORE visit and never outside STORE.
REQ-030 byte_count SHALL saturate at MAX_BYTES, never wrap, and hold its value in IDLE until the next packet start.
REQ-031 byte_done and qualified eop in the same RECEIVE cycle SHALL resolve to DONE; the byte SHALL be discarded.
REQ-032 Unreachable state encodings SHALL return to IDLE on the next clock.

Reset
REQ-033 On n_rst=0, asynchronously: state=IDLE, det_en=0, det_clear=0, rcving=0, w_enable=0, r_error=0, byte_count=0.
REQ-034 Reset asserted mid-packet SHALL abort without a write; first post-reset d_edge starts a fresh packet.

Verification
REQ-035 Good packet: d_edge, SYNC 8'h80, 3 bytes, qualified eop -> 3 w_enable pulses, byte_count=3, r_error=0, rcving falls 1 cycle after DONE.
REQ-036 Bad SYNC 8'h81 then bytes then eop -> no w_enable, r_error=1 until next d_edge, back to IDLE after eop.
REQ-037 buffer_full=1 at second byte -> exactly 1 write, r_error=1, ERR_WAIT held until qualified eop.
REQ-038 MAX_BYTES=4, send 5 bytes -> 4 writes, byte_count=4, r_error=1.
REQ-039 eop_error asserted with bit_en=0 then bit_en=1 -> ignored first cycle, ERR_WAIT entered second; SYNC+eop with zero bytes -> r_error=1.
REQ-040 n_rst pulsed during RECEIVE -> all outputs zero immediately; next good packet received correctly.
